datamem_bytectl: RTL
====================

Name: datamem_bytectl

Overview:
Parametrised data memory for the single-cycle/multi-cycle CPU datapath, and the successor of the fixed 32-word data memory.
- Adds byte, halfword and word stores with lane masking.
- Adds sign- or zero-extended sub-word loads.
- Adds a registered read with a valid strobe and misalignment detection.
- Adds a post-reset clear sweep.
- Sits between the ALU address result and the write-back mux.

Parameters:
DEPTH, 32, number of 32-bit words; power of two, minimum 4.
IDX_W, $clog2(DEPTH), localparam: word-index width; never overridden.

Ports:
Clk  input  1  clock; all state updates on rising edge.
Rst  input  1  asynchronous, active-high reset.
Req  input  1  access request; accepted only when Req & Ready.
We  input  1  1 = store, 0 = load; sampled with Req.
Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
Sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
Addr  input  32  byte address; bits [IDX_W+1:2] select the word, bits [1:0] select the lane.
Din  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
Ready  output  1  block can accept a request this cycle.
Dout  output  32  load result, extended to 32 bits.
Dvalid  output  1  one-cycle pulse: Dout is valid for the previous accepted load.
Misalign  output  1  one-cycle pulse: the previous accepted access was rejected.

Behaviour:
Reset (asynchronous, Rst=1):
- Ready=0, Dout=0, Dvalid=0, Misalign=0, sweep counter=0.
- FSM goes to CLR when DATAMEM_CLR_EN is defined, otherwise to RUN.
- Memory array contents are not reset directly.

FSM states: CLR, RUN.
- CLR: each cycle, write 32'h0 to word[cnt] and increment cnt. After DEPTH cycles (cnt = DEPTH-1 written), go to RUN.
- Ready=0 throughout CLR. Ready goes to 1 on the first RUN cycle.
- Rst asserted mid-sweep restarts the sweep from word 0.
- RUN: Ready=1 permanently. One request is accepted per cycle, and back-to-back requests are allowed.
- Req while Ready=0 is dropped with no side effects. The requester must hold Req until Ready=1.

Addressing:
- Addr bits above IDX_W+1 are ignored, so addresses wrap modulo DEPTH*4.
- Byte order is little-endian: lane 0 = bits [7:0].

Misalignment rule (checked at acceptance):
- Size=01 with Addr[0]=1.
- Size=10 with Addr[1:0]≠0.
- Size=11 (always).
- On misalignment: no memory write. Next cycle Misalign=1.
- For a misaligned load: Dvalid=1 and Dout=0 next cycle.

Stores (aligned):
- Written at the same rising edge as acceptance.
- Byte: Din[7:0] goes to lane Addr[1:0].
- Half: Din[15:0] goes to lanes {Addr[1],0} and {Addr[1],1}.
- Word: the full 32 bits are written.
- Unselected lanes are untouched.
- Dvalid stays 0 for stores.

Loads (aligned):
- Latency is 1 cycle: the array is read at the acceptance edge, and Dout/Dvalid are registered.
- Dvalid pulses for exactly one cycle.
- Dout holds its value until the next accepted load.
- The selected byte or half is right-justified, then extended per Sext.
- A load immediately following a store to the same word returns the new data.

Optional Feature:
Macro DATAMEM_CLR_EN.
- Defined: CLR sweep runs after every reset. Ready=0 for exactly DEPTH cycles after Rst deasserts, and all words read 0 afterwards.
- Undefined: no CLR state and no sweep counter. Ready=1 from the first cycle after Rst deasserts, and memory contents are undefined until written.

Decomposition:
- Shared package/header (`datamem_defs`):
  - size codes: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - FSM state encodings: ST_CLR, ST_RUN.
- One sub-module, `datamem_lane`: combinational.
  - Store side: generates the 4-bit lane write mask and the shifted write data from Size and Addr[1:0].
  - Load side: extracts and extends from the read word, using Size, Addr[1:0] and Sext.
  - Instantiated once for the store path and once for the load path, or with both functions in one instance.
- The top level holds the FSM, the array, and the output registers.

Test Plan:
- Clear sweep (DATAMEM_CLR_EN, DEPTH=32): release Rst → Ready=0 for 32 cycles then 1; a word load of any address → Dout=0, Dvalid pulse one cycle later.
- Byte lanes: word store 0x11223344 @0x8, then byte store 0xAA @0xA, then word load @0x8 → Dout=0x11AA3344.
- Extension: after the previous scenario, byte load @0xA with Sext=1 → 0xFFFFFFAA; with Sext=0 → 0x000000AA. Half load @0xA with Sext=1 → 0x000011AA.
- Misalignment: word store 0xDEADBEEF @0x6 → Misalign=1 next cycle and word @0x4 unchanged. Half load @0x3 → Misalign=1, Dvalid=1, Dout=0.
- Wrap and back-to-back: store 0x5 @0x80 (DEPTH=32), then load @0x0 on the next cycle → Dout=0x5. Four consecutive loads → four consecutive Dvalid pulses.
- Reset mid-sweep: assert Rst at sweep cycle 10 → Ready stays 0, and the sweep restarts with 32 full cycles.

Source files
------------

// File: rtl/datamem_bytectl_pkg.sv
// Shared definitions for the byte-lane data memory: size codes, FSM states,
// and the alignment rule applied when a request is accepted.
package datamem_defs;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Reserved size code is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = lane[0];
            SZ_W:    is_misaligned = |lane;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/datamem_bytectl_lane.sv
// Combinational lane steering: store mask/data replication and load
// extraction with sign or zero extension.
module datamem_lane
    import datamem_defs::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sext,
    input  logic [31:0] din,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] rext
);

    logic [31:0] shifted;

    always_comb begin
        wmask   = 4'b0000;
        wdata   = din;
        shifted = rdata >> {lane, 3'b000};
        rext    = '0;
        case (size)
            SZ_B: begin
                wmask = 4'b0001 << lane;
                wdata = {4{din[7:0]}};
                rext  = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wmask = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
                rext  = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                wmask = 4'b1111;
                rext  = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datamem_bytectl.sv
// Byte-addressable data memory with registered loads and misalign pulses.
// Optional post-reset clear sweep enabled by defining DATAMEM_CLR_EN.
module datamem_bytectl
    import datamem_defs::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        We,
    input  logic [1:0]  Size,
    input  logic        Sext,
    input  logic [31:0] Addr,
    input  logic [31:0] Din,
    output logic        Ready,
    output logic [31:0] Dout,
    output logic        Dvalid,
    output logic        Misalign
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             accept, mis, store_en;
    logic [3:0]       wmask;
    logic [31:0]      wdata, rword, rext;
    logic             ready_q, ready_d, dvalid_q, dvalid_d, mis_q, mis_d;
    logic [31:0]      dout_q, dout_d;
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;
    logic             unused_addr;

    assign idx         = Addr[IDX_W+1:2];
    assign lane        = Addr[1:0];
    assign unused_addr = ^Addr[31:IDX_W+2];
    assign rword       = mem[idx];
    assign accept      = Req & ready_q;
    assign mis         = is_misaligned(Size, lane);
    assign store_en    = accept & We & ~mis;

    datamem_lane u_lane (
        .size  (Size),
        .lane  (lane),
        .sext  (Sext),
        .din   (Din),
        .rdata (rword),
        .wmask (wmask),
        .wdata (wdata),
        .rext  (rext)
    );

`ifdef DATAMEM_CLR_EN
    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: ready_d = 1'b1;
        endcase
    end
    assign clr_idx = cnt_q;
`else
    assign ready_d = 1'b1;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    always_comb begin
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        mis_d    = 1'b0;
        if (accept) begin
            mis_d = mis;
            if (!We) begin
                dvalid_d = 1'b1;
                dout_d   = mis ? 32'h0 : rext;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
`ifdef DATAMEM_CLR_EN
            state_q <= ST_CLR;
            cnt_q   <= '0;
`endif
            ready_q  <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
`ifdef DATAMEM_CLR_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
            ready_q  <= ready_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            mis_q    <= mis_d;
        end
    end

    // Array has no reset; the clear sweep and stores share one write port.
    always_ff @(posedge Clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign Ready    = ready_q;
    assign Dout     = dout_q;
    assign Dvalid   = dvalid_q;
    assign Misalign = mis_q;

endmodule
